// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver, 16x oversampled with mid-bit sampling and a start-glitch filter.
// received fires ~2+9.5 bit times after the start edge; no backpressure, each byte is a one-clock strobe.
module uart_rx_byte #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] incoming_byte,
  output logic       received,
  output logic       framing_error,
  output logic       busy
);

  localparam int DIV_RAW = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW      = $clog2(OVERSAMPLE);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [SW-1:0] SMP_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SMP_LAST = SW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state, state_n;
  logic          rx_meta, rxs;
  logic [DW-1:0] div_cnt;
  logic [SW-1:0] smp_cnt, smp_n;
  logic [2:0]    bit_idx, idx_n;
  logic [7:0]    shreg, sh_n;
  logic [7:0]    byte_n;
  logic          rcv_n, fe_n;
  logic          tick;

  // Divider is parked at zero in IDLE so tick phase lines up with the start edge.
  assign tick = (state != S_IDLE) && (div_cnt == DIV_LAST);
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta       <= 1'b1;
      rxs           <= 1'b1;
      state         <= S_IDLE;
      div_cnt       <= '0;
      smp_cnt       <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      incoming_byte <= '0;
      received      <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      rx_meta       <= rx;
      rxs           <= rx_meta;
      state         <= state_n;
      div_cnt       <= (state == S_IDLE || tick) ? '0 : div_cnt + 1'b1;
      smp_cnt       <= smp_n;
      bit_idx       <= idx_n;
      shreg         <= sh_n;
      incoming_byte <= byte_n;
      received      <= rcv_n;
      framing_error <= fe_n;
    end
  end

  always_comb begin
    state_n = state;
    smp_n   = smp_cnt;
    idx_n   = bit_idx;
    sh_n    = shreg;
    byte_n  = incoming_byte;
    rcv_n   = 1'b0;
    fe_n    = 1'b0;
    case (state)
      S_IDLE: begin
        smp_n = '0;
        if (!rxs) state_n = S_START;
      end
      S_START: begin
        if (tick) begin
          if (smp_cnt == SMP_HALF) begin
            smp_n = '0;
            idx_n = '0;
            // Line back high before mid start bit: treat as a glitch.
            state_n = rxs ? S_IDLE : S_DATA;
          end else begin
            smp_n = smp_cnt + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (smp_cnt == SMP_LAST) begin
            smp_n         = '0;
            sh_n[bit_idx] = rxs;
            if (bit_idx == 3'd7) state_n = S_STOP;
            else idx_n = bit_idx + 1'b1;
          end else begin
            smp_n = smp_cnt + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (smp_cnt == SMP_LAST) begin
            smp_n = '0;
            if (rxs) begin
              byte_n  = shreg;
              rcv_n   = 1'b1;
              state_n = S_IDLE;
            end else begin
              fe_n    = 1'b1;
              state_n = S_BREAK;
            end
          end else begin
            smp_n = smp_cnt + 1'b1;
          end
        end
      end
      S_BREAK: begin
        if (rxs) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboarded bench for uart_rx_byte: stimulus queues expected strobes, a negedge monitor checks them.
module tb_uart_rx_byte;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] incoming_byte;
  logic       received;
  logic       framing_error;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic       fe;
    logic [7:0] d;
    int         lo;
    int         hi;
  } exp_t;

  exp_t       q[$];
  logic [7:0] exp_last = 8'h00;

  uart_rx_byte #(
    .CLK_FREQ  (1600000),
    .BAUD      (100000),
    .OVERSAMPLE(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .incoming_byte(incoming_byte),
    .received     (received),
    .framing_error(framing_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, expv);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bit k is driven right after posedge start+per*k; strobe is due 155 posedges after start.
  task automatic send_frame(input logic [7:0] d, input int per, input logic stop_b, input bit push);
    exp_t e;
    if (push) begin
      e.fe = !stop_b;
      e.d  = d;
      e.lo = (per == 16) ? cyc + 154 : cyc;
      e.hi = (per == 16) ? cyc + 156 : cyc + 100000;
      q.push_back(e);
    end
    rx = 1'b0;
    wait_cyc(per);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_cyc(per);
    end
    rx = stop_b;
    wait_cyc(per);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_last = 8'h00;
    end else begin
      if (received && framing_error) chk("strobe_exclusive", 32'd1, 32'd0);
      if (received || framing_error) begin
        if (q.size() == 0) begin
          chk("unexpected_strobe", {received, framing_error}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("strobe_kind_fe", framing_error, e.fe);
          if (e.fe) begin
            chk("fe_byte_kept", incoming_byte, exp_last);
          end else begin
            chk("rx_byte", incoming_byte, e.d);
            exp_last = e.d;
          end
          total++;
          if (cyc < e.lo || cyc > e.hi) begin
            bad++;
            $display("FAIL strobe_latency got_cycle=%0d want=%0d..%0d", cyc, e.lo, e.hi);
          end
        end
      end else begin
        chk("byte_stable", incoming_byte, exp_last);
      end
    end
  end

  initial begin
    exp_t  e;
    logic [7:0] d;
    bit    err;

    // Reset with the line held low.
    rst = 1'b1;
    rx  = 1'b0;
    wait_cyc(3);
    chk("rst_byte", incoming_byte, 8'h00);
    chk("rst_received", received, 1'b0);
    chk("rst_fe", framing_error, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst  = 1'b0;
    e.fe = 1'b1;
    e.d  = 8'h00;
    e.lo = cyc + 154;
    e.hi = cyc + 156;
    q.push_back(e);
    wait_cyc(200);
    chk("busy_in_break_from_reset", busy, 1'b1);
    rx = 1'b1;
    wait_cyc(10);
    chk("idle_after_break", busy, 1'b0);

    // Single frame, then a framing error that must keep the byte, then recovery.
    send_frame(8'hA5, 16, 1'b1, 1);
    wait_cyc(10);
    send_frame(8'h55, 16, 1'b0, 1);
    wait_cyc(40);
    chk("busy_in_break", busy, 1'b1);
    rx = 1'b1;
    wait_cyc(20);
    chk("idle_after_line_high", busy, 1'b0);
    send_frame(8'h0F, 16, 1'b1, 1);
    wait_cyc(10);

    // Back-to-back with zero idle bits.
    send_frame(8'h3C, 16, 1'b1, 1);
    send_frame(8'h12, 16, 1'b1, 1);
    wait_cyc(20);

    // Short start glitch.
    rx = 1'b0;
    wait_cyc(4);
    rx = 1'b1;
    wait_cyc(2);
    chk("glitch_busy_high", busy, 1'b1);
    wait_cyc(10);
    chk("glitch_busy_dropped", busy, 1'b0);
    wait_cyc(20);

    // Reset at bit 4 of 0x81.
    d  = 8'h81;
    rx = 1'b0;
    wait_cyc(16);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      wait_cyc(16);
    end
    rx = d[4];
    wait_cyc(4);
    rst = 1'b1;
    #1;
    chk("midrst_byte", incoming_byte, 8'h00);
    chk("midrst_received", received, 1'b0);
    chk("midrst_fe", framing_error, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    rx = 1'b1;
    wait_cyc(5);
    rst = 1'b0;
    wait_cyc(20);
    send_frame(8'h7E, 16, 1'b1, 1);
    wait_cyc(10);

    // Baud tolerance.
    send_frame(8'hC3, 15, 1'b1, 1);
    wait_cyc(30);
    send_frame(8'hC3, 17, 1'b1, 1);
    wait_cyc(30);

    // Random traffic with occasional line faults.
    for (int k = 0; k < 24; k++) begin
      d   = 8'($urandom);
      err = ($urandom_range(0, 7) == 0);
      send_frame(d, 16, !err, 1);
      if (err) begin
        rx = 1'b0;
        wait_cyc($urandom_range(5, 40));
      end
      rx = 1'b1;
      wait_cyc(err ? 5 : $urandom_range(0, 6));
    end

    wait_cyc(200);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
Upstream stage of the UART-to-memory byte-pair parser. Receives an asynchronous 8N1 serial stream on a single line and emits each completed byte with a one-clock `received` strobe. The parser alternately captures these bytes as data and address. Uses 16x oversampling with mid-bit sampling and a start-bit glitch filter, and reports framing errors.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
BAUD, 115200, serial bit rate
OVERSAMPLE, 16, ticks per bit; must be even and >= 4
DIV, CLK_FREQ/(BAUD*OVERSAMPLE) rounded to nearest, minimum 1: clocks per oversample tick (localparam)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
rx  input  1  serial line, idle high, asynchronous to clk
incoming_byte  output  8  last correctly framed byte, LSB received first
received  output  1  one-clock pulse when incoming_byte is updated
framing_error  output  1  one-clock pulse when the stop bit samples low
busy  output  1  high from start-bit detection until return to IDLE

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; incoming_byte=0x00; received=0; framing_error=0; busy=0.
  - Synchronizer flops set to 1 (idle level).
  - Tick counter and bit counter cleared.
  - Reset mid-frame abandons the frame; no strobe is produced for it.
- Input sync: two-flop synchronizer on rx. All decisions use the synchronized value rxs. Adds 2 clocks of latency.
- Tick generator:
  - Counter 0..DIV-1; tick is high for one clk when the counter wraps.
  - Free-running only while state != IDLE; held at 0 in IDLE so phase aligns to the start edge.
- States:
  - IDLE: busy=0. If rxs==0, go to START and clear the tick count (busy=1 next cycle).
  - START: on tick OVERSAMPLE/2 (mid start bit):
    - if rxs==0, go to DATA with bit index 0 and sample count 0;
    - else (glitch shorter than half a bit) go to IDLE with no strobe.
  - DATA: every OVERSAMPLE ticks (mid-bit), shift rxs into shift register bit[idx], LSB first. After idx 7, go to STOP.
  - STOP: after OVERSAMPLE ticks (mid stop bit):
    - rxs==1: incoming_byte <= shift register; received=1 for exactly one clk; go to IDLE.
    - rxs==0: framing_error=1 for one clk; incoming_byte unchanged; received stays 0; go to BREAK.
  - BREAK: wait until rxs==1, then go to IDLE. A low line (break/line fault) never produces bytes.
- Timing:
  - received rises 2 + (DIV*OVERSAMPLE*9.5) clocks (±DIV) after the rx falling edge.
  - Returning to IDLE at mid stop bit allows back-to-back frames with zero idle bits.
- received and framing_error are mutually exclusive and never asserted on consecutive cycles for the same frame.
- incoming_byte is stable between received pulses, so downstream may capture on the received rising edge.
- rx held low out of reset: the frame is treated as a start, then a framing error, then BREAK until rx goes high.

Test Plan:
Use CLK_FREQ=1600000, BAUD=100000, OVERSAMPLE=16 (DIV=1, 16 clk/bit).
1. Single frame 0xA5 after idle -> incoming_byte=0xA5; received high exactly 1 clk, 154±1 clks after the start edge; framing_error=0.
2. Back-to-back 0x3C then 0x12 with no idle bits -> two received pulses ~160 clks apart; incoming_byte 0x3C then 0x12. Feeding both into the pair parser writes data 0x3C at address 0x12.
3. rx low glitch of 4 clks -> busy pulses then drops by clk ~10; no received, no framing_error; incoming_byte unchanged.
4. Frame 0x55 with stop bit driven 0 and rx held low 40 more clks -> one framing_error pulse; incoming_byte keeps the prior value 0xA5; busy stays 1 until rx high. A following 0x0F frame is received correctly.
5. Assert rst at bit 4 of frame 0x81 -> outputs go 0 immediately. The partial frame produces no strobe. A clean 0x7E sent after release yields received with incoming_byte=0x7E.
6. Baud tolerance: 0xC3 sent with bit period 15 and then 17 clks (±6%) -> received with incoming_byte=0xC3 in both cases.
